// File: rtl/button_sel_counter_if.sv
// Button inputs and debounced/select outputs of button_sel_counter.
// The master side drives the raw buttons; the slave side is the counter.
interface button_sel_counter_if;
    logic       btn_up;
    logic       btn_down;
    logic       up_db;
    logic       down_db;
    logic [2:0] sel;
    logic       sel_changed;

    modport master (
        output btn_up, btn_down,
        input  up_db, down_db, sel, sel_changed
    );

    modport slave (
        input  btn_up, btn_down,
        output up_db, down_db, sel, sel_changed
    );
endinterface

// File: rtl/button_sel_counter.sv
// 3-bit mux select stepped up/down by two raw push-buttons, each synchronised,
// debounced and rising-edge detected; select wraps or saturates.
module button_sel_counter #(
    parameter int unsigned DB_TICKS = 20,
    parameter int unsigned WRAP     = 1
) (
    input logic                 clk,
    input logic                 reset,
    button_sel_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

    localparam int unsigned    CW       = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_TICKS - 1);

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    btn_s;
    db_state_t     state_q [2];
    db_state_t     state_d [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [1:0]    db;
    logic [1:0]    db_q;
    logic [1:0]    press;
    logic [2:0]    sel_q;
    logic [2:0]    sel_d;
    logic          changed_q;
    logic          changed_d;

    assign raw = {bus.btn_down, bus.btn_up};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            btn_s     <= '0;
            db_q      <= '0;
            sel_q     <= '0;
            changed_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= IDLE_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1     <= raw;
            btn_s     <= sync1;
            db_q      <= db;
            sel_q     <= sel_d;
            changed_q <= changed_d;
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        db = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE_LOW: begin
                    if (btn_s[i]) begin
                        state_d[i] = WAIT_HIGH;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!btn_s[i])                state_d[i] = IDLE_LOW;
                    else if (cnt_q[i] == CNT_LAST) state_d[i] = IDLE_HIGH;
                    else                          cnt_d[i]   = cnt_q[i] + CW'(1);
                end
                IDLE_HIGH: begin
                    if (!btn_s[i]) begin
                        state_d[i] = WAIT_LOW;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_LOW: begin
                    if (btn_s[i])                 state_d[i] = IDLE_HIGH;
                    else if (cnt_q[i] == CNT_LAST) state_d[i] = IDLE_LOW;
                    else                          cnt_d[i]   = cnt_q[i] + CW'(1);
                end
                default: state_d[i] = IDLE_LOW;
            endcase
            db[i] = (state_q[i] == IDLE_HIGH) || (state_q[i] == WAIT_LOW);
        end
    end

    assign press = db & ~db_q;

    // Simultaneous up and down presses cancel; saturation shows up as no change.
    always_comb begin
        sel_d = sel_q;
        case (press)
            2'b01: if (WRAP != 0 || sel_q != 3'd7) sel_d = sel_q + 3'd1;
            2'b10: if (WRAP != 0 || sel_q != 3'd0) sel_d = sel_q - 3'd1;
            default: sel_d = sel_q;
        endcase
        changed_d = (sel_d != sel_q);
    end

    assign bus.up_db       = db[0];
    assign bus.down_db     = db[1];
    assign bus.sel         = sel_q;
    assign bus.sel_changed = changed_q;

endmodule

// File: tb/tb_button_sel_counter.sv
// Scoreboard bench for button_sel_counter: one wrapping and one saturating
// instance share the same button stimulus and are checked against a run-length model.
module tb_button_sel_counter;

    localparam int DB = 4;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic up = 1'b0;
    logic dn = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state
    logic [1:0] ms1, ms2, mdb, mdbq;
    int         run[2];
    int         msel[2];

    button_sel_counter_if bw();
    button_sel_counter_if bs();

    assign bw.btn_up   = up;
    assign bw.btn_down = dn;
    assign bs.btn_up   = up;
    assign bs.btn_down = dn;

    button_sel_counter #(.DB_TICKS(DB), .WRAP(1)) dut_w (.clk(clk), .reset(reset), .bus(bw));
    button_sel_counter #(.DB_TICKS(DB), .WRAP(0)) dut_s (.clk(clk), .reset(reset), .bus(bs));

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ms1 = '0; ms2 = '0; mdb = '0; mdbq = '0;
        run[0] = 0; run[1] = 0;
        msel[0] = 0; msel[1] = 0;
    endtask

    // Debounced level flips once the synchronised input has disagreed with it
    // for DB+1 consecutive samples; presses are debounced rising edges.
    task automatic model_step();
        logic [1:0] pr;
        int nxt;
        exp_t e;
        cyc++;
        pr = mdb & ~mdbq;
        for (int d = 0; d < 2; d++) begin
            nxt = msel[d];
            if (pr == 2'b01)
                nxt = (d == 0) ? (msel[d] + 1) % 8 : ((msel[d] == 7) ? 7 : msel[d] + 1);
            else if (pr == 2'b10)
                nxt = (d == 0) ? (msel[d] + 7) % 8 : ((msel[d] == 0) ? 0 : msel[d] - 1);
            if (nxt != msel[d]) begin
                msel[d] = nxt;
                e.cyc = cyc;
                e.sel = nxt[2:0];
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
        mdbq = mdb;
        for (int b = 0; b < 2; b++) begin
            if (ms2[b] != mdb[b]) begin
                run[b]++;
                if (run[b] == DB + 1) begin
                    mdb[b] = ms2[b];
                    run[b] = 0;
                end
            end else begin
                run[b] = 0;
            end
        end
        ms2 = ms1;
        ms1 = {dn, up};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    task automatic mon(input int d, input logic [2:0] s, input logic sc,
                       input logic ud, input logic dd);
        exp_t e;
        string tag;
        tag = (d == 0) ? "wrap" : "sat";
        chk({tag, " up_db"}, {31'd0, ud}, {31'd0, mdb[0]});
        chk({tag, " down_db"}, {31'd0, dd}, {31'd0, mdb[1]});
        chk({tag, " sel"}, {29'd0, s}, msel[d]);
        if (sc === 1'b1) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                chk({tag, " spurious sel_changed"}, 32'd1, 32'd0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk({tag, " sel_changed cycle"}, cyc, e.cyc);
                chk({tag, " sel_changed value"}, {29'd0, s}, {29'd0, e.sel});
            end
        end else begin
            chk({tag, " sel_changed known"}, {31'd0, (sc === 1'b0)}, 32'd1);
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon(0, bw.sel, bw.sel_changed, bw.up_db, bw.down_db);
        mon(1, bs.sel, bs.sel_changed, bs.up_db, bs.down_db);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic bu, input logic bd);
        up = bu; dn = bd;
        cycles(10);
        up = 1'b0; dn = 1'b0;
        cycles(10);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        #2;
        chk("reset sel wrap", {29'd0, bw.sel}, 32'd0);
        chk("reset sel_changed wrap", {31'd0, bw.sel_changed}, 32'd0);
        chk("reset up_db sat", {31'd0, bs.up_db}, 32'd0);
        chk("reset sel sat", {29'd0, bs.sel}, 32'd0);
        cycles(2);
        reset = 1'b0;

        // Held press: exactly one step
        up = 1'b1;
        cycles(20);
        up = 1'b0;
        cycles(12);

        // Bounces shorter than the debounce window
        up = 1'b1; cycles(3);
        up = 1'b0; cycles(3);
        up = 1'b1; cycles(3);
        up = 1'b0; cycles(10);

        repeat (8) press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);

        // Down at zero, then climb past seven
        pulse_reset();
        press(1'b0, 1'b1);
        repeat (8) press(1'b1, 1'b0);

        // Random bouncy episodes
        for (int ep = 0; ep < 30; ep++) begin
            n = $urandom_range(1, 12);
            repeat (n) begin
                up = 1'($urandom_range(0, 1));
                dn = 1'($urandom_range(0, 1));
                cycles(1);
            end
            up = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
            cycles($urandom_range(0, 12));
        end
        up = 1'b0; dn = 1'b0;
        cycles(15);

        // Async reset while up is in WAIT_HIGH at sel=5
        pulse_reset();
        repeat (5) press(1'b1, 1'b0);
        chk("pre-abort sel", {29'd0, bw.sel}, 32'd5);
        up = 1'b1;
        cycles(5);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort sel wrap", {29'd0, bw.sel}, 32'd0);
        chk("abort up_db wrap", {31'd0, bw.up_db}, 32'd0);
        chk("abort sel sat", {29'd0, bs.sel}, 32'd0);
        #1 reset = 1'b0;
        n = 0;
        while (bw.sel_changed !== 1'b1 && n < 20) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("post-reset press latency", n, DB + 4);
        chk("post-reset sel", {29'd0, bw.sel}, 32'd1);
        cycles(5);
        up = 1'b0;
        cycles(15);

        chk("wrap pending expectations", q0.size(), 32'd0);
        chk("sat pending expectations", q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_sel_counter.md
Name: button_sel_counter

Overview:
- Generates the 3-bit select that drives the 8-to-1 n-bit channel multiplexer from two raw push-buttons (up/down).
- Each button is synchronised, debounced by an FSM and rising-edge detected.
- Each clean press steps the select by one, wrapping or saturating.
- Sits directly upstream of the mux; its sel output connects to the mux select input.

Parameters:
- DB_TICKS, 20, consecutive stable synchronised samples required to accept a level change (>=1; board builds use ~2_000_000).
- WRAP, 1, 1 = select wraps 7<->0; 0 = select saturates at 0 and 7.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- btn_up  input  1  raw, asynchronous, bouncy up button
- btn_down  input  1  raw, asynchronous, bouncy down button
- up_db  output  1  debounced level of btn_up
- down_db  output  1  debounced level of btn_down
- sel  output  3  registered channel select to the mux
- sel_changed  output  1  one-cycle pulse in the first cycle sel holds a new value

Behaviour:
- Reset (async, active-high): synchroniser FFs=0, both FSMs in IDLE_LOW, debounce counters=0, up_db=0, down_db=0, sel=3'd0, sel_changed=0.
- Reset asserted mid-debounce or mid-press aborts all activity. After release, a button still held must complete a full fresh debounce before it counts as a press.
- Synchroniser: two-FF chain per button. The FSM sees only the second FF (btn_s).
- Debounce FSM, one per button. States: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. Counter width max(1,$clog2(DB_TICKS)).
  - IDLE_LOW: btn_s=1 -> WAIT_HIGH, cnt=0.
  - WAIT_HIGH: btn_s=0 -> IDLE_LOW (glitch rejected). Else cnt==DB_TICKS-1 -> IDLE_HIGH. Else cnt++.
  - IDLE_HIGH: btn_s=0 -> WAIT_LOW, cnt=0.
  - WAIT_LOW: mirror of WAIT_HIGH; btn_s=1 returns to IDLE_HIGH.
  - Moore output: *_db=1 in IDLE_HIGH and WAIT_LOW, else 0.
- Debounce latency: input first sampled high at edge 1 and held gives *_db=1 after edge DB_TICKS+3. Release latency is identical.
- Edge detect: press pulse = *_db & ~*_db_q (_q is a one-cycle registered copy). Exactly one pulse per debounced rising edge. Release generates no pulse.
- Select update, registered at the edge after the pulse:
  - up pulse only: sel+1. 7 -> 0 if WRAP=1; stays 7 if WRAP=0.
  - down pulse only: sel-1. 0 -> 7 if WRAP=1; stays 0 if WRAP=0.
  - both pulses in the same cycle: sel unchanged (cancel).
  - no pulse: hold.
- sel_changed: registered, high for exactly the one cycle after sel takes a different value. Low on cancel and on saturation no-op.
- End-to-end: btn_up held from edge 1 gives the new sel and sel_changed=1 after edge DB_TICKS+4.
- Holding a button produces exactly one step (no auto-repeat).
- sel never takes X; all arithmetic is 3-bit modulo.

Test Plan:
- DB_TICKS=4, WRAP=1, reset then btn_up high from edge 1 held 20 cycles -> up_db rises after edge 7; sel 0->1 and sel_changed=1 after edge 8 for exactly one cycle; no further change while held.
- Glitch rejection: btn_up high 3 cycles, low 3, high 3, low -> up_db stays 0, sel stays 0, sel_changed never asserts.
- Wrap: 8 clean up presses from sel=0 -> sel steps 1..7 then 0, 8 sel_changed pulses. Then one down press -> sel=7.
- Simultaneous: btn_up and btn_down rise on the same edge and both held -> both *_db rise together; sel unchanged; sel_changed stays 0.
- WRAP=0 saturation: down press at sel=0 -> sel=0, no sel_changed. 7 up presses then one more -> sel=7, only 7 pulses total.
- Async reset mid-operation: sel=5, btn_up held, reset pulsed between clock edges during WAIT_HIGH -> sel=0 and up_db=0 immediately. After release with btn_up still held, sel=1 exactly DB_TICKS+4 edges later.
